// File: rtl/down_counter.sv
// Debounced down-counter.
// A raw push-button is synchronized, debounced by a four-state FSM and turned
// into a one-cycle decrement pulse. Each accepted press decrements a WIDTH-bit
// count with wrap-around; a wrap from 0 raises a one-cycle underflow pulse.
// A synchronous preset load overrides a coincident decrement.
module down_counter #(
  parameter int WIDTH     = 3,
  parameter int DB_CYCLES = 4   // stable samples needed to accept a change, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             down_db
);

  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic             s1_q;
  logic             down_s_q;
  state_e           state_q,   state_d;
  logic [CW-1:0]    db_cnt_q,  db_cnt_d;
  logic             down_db_q, down_db_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic             underflow_q, underflow_d;

  // Two-flop synchronizer bringing the asynchronous button into the clk domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      down_s_q <= 1'b0;
    end else begin
      s1_q     <= down;
      down_s_q <= s1_q;
    end
  end

  // Debounce FSM next-state, stability counter and press pulse.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    down_db_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (down_s_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!down_s_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = HELD;
          down_db_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!down_s_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        // A re-high during release is bounce: back to HELD without a pulse.
        if (down_s_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Count next-state: load beats decrement, and a discarded pulse is not kept.
  always_comb begin
    count_d     = count_q;
    underflow_d = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (down_db_q) begin
      count_d     = count_q - WIDTH'(1);
      underflow_d = (count_q == '0);
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      down_db_q   <= 1'b0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      down_db_q   <= down_db_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign underflow = underflow_q;
  assign down_db   = down_db_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios followed by
// randomized button/load/reset traffic, all checked every cycle against a
// run-length reference model of the debouncer and an arithmetic count model.
module tb_down_counter;

  localparam int W  = 3;
  localparam int DB = 4;

  logic         clk;
  logic         rst;
  logic         down;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         underflow;
  logic         down_db;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  logic         m_s1, m_s2;     // button as seen through two clock delays
  bit           m_held;         // a press has been accepted and not yet released
  int           m_run;          // consecutive high samples while not held
  int           m_lowrun;       // consecutive low samples while held
  logic         m_db;
  logic [W-1:0] m_count;
  logic         m_uf;

  int uf_seen;
  int db_seen;

  down_counter #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .down      (down),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .underflow (underflow),
    .down_db   (down_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_held = 1'b0; m_run = 0; m_lowrun = 0;
    m_db = 1'b0; m_count = '0; m_uf = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge values.
  task automatic model_edge();
    logic new_db;
    if (load) begin
      m_count = load_value;
      m_uf    = 1'b0;
    end else if (m_db) begin
      m_uf    = (m_count == 0);
      m_count = m_count - 1'b1;
    end else begin
      m_uf = 1'b0;
    end
    new_db = 1'b0;
    if (!m_held) begin
      m_run = m_s2 ? m_run + 1 : 0;
      if (m_run == DB + 1) begin
        new_db = 1'b1; m_held = 1'b1; m_run = 0; m_lowrun = 0;
      end
    end else begin
      m_lowrun = m_s2 ? 0 : m_lowrun + 1;
      if (m_lowrun == DB + 1) begin
        m_held = 1'b0; m_lowrun = 0; m_run = 0;
      end
    end
    m_db = new_db;
    m_s2 = m_s1;
    m_s1 = down;
  endtask

  task automatic compare_all(input string tag);
    check({tag, " count"},     32'(count),     32'(m_count));
    check({tag, " underflow"}, 32'(underflow), 32'(m_uf));
    check({tag, " down_db"},   32'(down_db),   32'(m_db));
    if (underflow === 1'b1) uf_seen++;
    if (down_db === 1'b1) db_seen++;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) model_reset();
    #1;
    compare_all("rst");
  endtask

  // Hold the button for hi cycles, then release for lo cycles.
  task automatic press(input int hi, input int lo, input string tag);
    down = 1'b1;
    repeat (hi) step(tag);
    down = 1'b0;
    repeat (lo) step(tag);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v;
    step("load");
    load = 1'b0;
  endtask

  initial begin
    int waited;
    rst = 1'b1; down = 1'b1; load = 1'b0; load_value = '0;
    model_reset();
    uf_seen = 0; db_seen = 0;
    #1;
    compare_all("t1 async");

    // 1: reset held with the button down, then released.
    repeat (3) step("t1");
    set_rst(1'b0);
    down = 1'b0;
    repeat (4) step("t1");
    check("t1 count zero", 32'(count), 32'd0);
    check("t1 no pulse", 32'(db_seen), 32'd0);

    // 2: clean press from 5; decrement lands at edge k+7.
    do_load(3'd5);
    down = 1'b1;
    repeat (7) step("t2");
    check("t2 count before k+7", 32'(count), 32'd5);
    step("t2");
    check("t2 count at k+7", 32'(count), 32'd4);
    repeat (4) step("t2");
    down = 1'b0;
    repeat (10) step("t2");
    check("t2 count after release", 32'(count), 32'd4);
    check("t2 one pulse", 32'(db_seen), 32'd1);

    // 3: short glitch is rejected.
    press(3, 10, "t3");
    check("t3 count unchanged", 32'(count), 32'd4);
    check("t3 no pulse", 32'(db_seen), 32'd1);

    // 4: release bounce gives no second pulse.
    down = 1'b1;
    repeat (12) step("t4");
    down = 1'b0;
    repeat (2) step("t4");
    press(4, 10, "t4");
    check("t4 count", 32'(count), 32'd3);
    check("t4 pulses", 32'(db_seen), 32'd2);

    // 5: underflow from 0, then a normal decrement.
    do_load(3'd0);
    uf_seen = 0;
    press(12, 10, "t5");
    check("t5 wrapped count", 32'(count), 32'd7);
    check("t5 one underflow", 32'(uf_seen), 32'd1);
    press(12, 10, "t5b");
    check("t5b count", 32'(count), 32'd6);
    check("t5b no underflow", 32'(uf_seen), 32'd1);

    // 6: load on the same edge as a pulse wins and the press is lost.
    do_load(3'd2);
    down = 1'b1;
    waited = 0;
    do begin
      step("t6");
      waited++;
    end while (m_db !== 1'b1 && waited < 20);
    check("t6 pulse within budget", 32'(waited < 20), 32'd1);
    check("t6 pulse present", 32'(down_db), 32'd1);
    do_load(3'd6);
    check("t6 load wins", 32'(count), 32'd6);
    check("t6 underflow low", 32'(underflow), 32'd0);
    down = 1'b0;
    repeat (10) step("t6");
    check("t6 press lost", 32'(count), 32'd6);

    // 7: reset mid-press aborts; a button still held afterwards is a new press.
    down = 1'b1;
    repeat (4) step("t7");
    set_rst(1'b1);
    down = 1'b0;
    step("t7");
    set_rst(1'b0);
    repeat (10) step("t7");
    check("t7 count after abort", 32'(count), 32'd0);
    down = 1'b1;
    repeat (4) step("t7b");
    set_rst(1'b1);
    step("t7b");
    set_rst(1'b0);
    uf_seen = 0;
    repeat (12) step("t7b");
    down = 1'b0;
    repeat (10) step("t7b");
    check("t7b held through reset", 32'(count), 32'd7);
    check("t7b underflow", 32'(uf_seen), 32'd1);

    // Randomized segments of button levels with occasional loads and resets.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      down = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        load       = ($urandom_range(0, 15) == 0);
        load_value = W'($urandom);
        step("rand");
      end
      load = 1'b0;
      if ($urandom_range(0, 60) == 0) begin
        set_rst(1'b1);
        step("rand rst");
        set_rst(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
